// File: rtl/lpr_pkg.sv
// Shared types, widths and window helpers for the plate-capture window controller.
// Bound helpers widen before the margin is applied so underflow and overflow can be clamped.
package lpr_pkg;

  localparam int unsigned COORD_W = 12;
  localparam int unsigned CNT_W   = 20;

  localparam logic [COORD_W-1:0] COORD_CLEAR_MIN = 12'hFFF;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    ACCUM,
    CHECK,
    COMMIT
  } lpr_state_t;

  typedef struct packed {
    logic [COORD_W-1:0] h_l;
    logic [COORD_W-1:0] h_r;
    logic [COORD_W-1:0] v_l;
    logic [COORD_W-1:0] v_r;
  } lpr_win_t;

  localparam lpr_win_t NULL_WIN = '0;

  // Left/top bound: c - margin - 1, floored at 0.
  function automatic logic [COORD_W-1:0] bound_lo(input logic [COORD_W-1:0] c,
                                                  input int unsigned margin);
    logic [COORD_W+1:0] t;
    t = {2'b00, c} - (COORD_W+2)'(margin + 1);
    return t[COORD_W+1] ? '0 : t[COORD_W-1:0];
  endfunction

  // Right/bottom bound: c + margin + 1, capped at the active size.
  function automatic logic [COORD_W-1:0] bound_hi(input logic [COORD_W-1:0] c,
                                                  input int unsigned margin,
                                                  input int unsigned limit);
    logic [COORD_W+1:0] t;
    logic [COORD_W+1:0] lim;
    t   = {2'b00, c} + (COORD_W+2)'(margin + 1);
    lim = (COORD_W+2)'(limit);
    return (t > lim) ? lim[COORD_W-1:0] : t[COORD_W-1:0];
  endfunction

endpackage

// File: rtl/lpr_window_ctrl_if.sv
// Video-timing bundle from the colour/binarisation stage into the window controller.
interface lpr_window_ctrl_if;
  import lpr_pkg::*;

  logic               i_vsync;
  logic               i_de;
  logic               i_mask;
  logic [COORD_W-1:0] hcount;
  logic [COORD_W-1:0] vcount;

  modport master (output i_vsync, i_de, i_mask, hcount, vcount);
  modport slave  (input  i_vsync, i_de, i_mask, hcount, vcount);

endinterface

// File: rtl/lpr_bbox_accum.sv
// Bounding-box and pixel-count accumulators for mask pixels; clear has priority over accumulate.
module lpr_bbox_accum
  import lpr_pkg::*;
(
  input  logic               pixelclk,
  input  logic               reset_n,
  input  logic               i_clear,
  input  logic               i_en,
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  output logic [COORD_W-1:0] o_xmin,
  output logic [COORD_W-1:0] o_xmax,
  output logic [COORD_W-1:0] o_ymin,
  output logic [COORD_W-1:0] o_ymax,
  output logic [CNT_W-1:0]   o_pix_cnt
);

  logic [COORD_W-1:0] xmin_q, xmin_d, xmax_q, xmax_d;
  logic [COORD_W-1:0] ymin_q, ymin_d, ymax_q, ymax_d;
  logic [CNT_W-1:0]   pix_cnt_q, pix_cnt_d;

  always_comb begin
    xmin_d    = xmin_q;
    xmax_d    = xmax_q;
    ymin_d    = ymin_q;
    ymax_d    = ymax_q;
    pix_cnt_d = pix_cnt_q;
    if (i_clear) begin
      xmin_d    = COORD_CLEAR_MIN;
      xmax_d    = '0;
      ymin_d    = COORD_CLEAR_MIN;
      ymax_d    = '0;
      pix_cnt_d = '0;
    end else if (i_en) begin
      if (i_x < xmin_q) xmin_d = i_x;
      if (i_x > xmax_q) xmax_d = i_x;
      if (i_y < ymin_q) ymin_d = i_y;
      if (i_y > ymax_q) ymax_d = i_y;
      if (pix_cnt_q != '1) pix_cnt_d = pix_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      xmin_q    <= COORD_CLEAR_MIN;
      xmax_q    <= '0;
      ymin_q    <= COORD_CLEAR_MIN;
      ymax_q    <= '0;
      pix_cnt_q <= '0;
    end else begin
      xmin_q    <= xmin_d;
      xmax_q    <= xmax_d;
      ymin_q    <= ymin_d;
      ymax_q    <= ymax_d;
      pix_cnt_q <= pix_cnt_d;
    end
  end

  assign o_xmin    = xmin_q;
  assign o_xmax    = xmax_q;
  assign o_ymin    = ymin_q;
  assign o_ymax    = ymax_q;
  assign o_pix_cnt = pix_cnt_q;

endmodule

// File: rtl/lpr_window_ctrl.sv
// Per-frame crop-window controller: accumulates the mask bounding box over a frame, validates it at
// the vsync rise and commits margined, clamped bounds two cycles later, holding through dropouts.
module lpr_window_ctrl
  import lpr_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = 1280,
  parameter int unsigned V_ACTIVE    = 720,
  parameter int unsigned MARGIN      = 4,
  parameter int unsigned MIN_W       = 32,
  parameter int unsigned MIN_H       = 8,
  parameter int unsigned MIN_PIX     = 64,
  parameter int unsigned HOLD_FRAMES = 15
) (
  input  logic               pixelclk,
  input  logic               reset_n,
  input  logic               i_enable,
  lpr_window_ctrl_if.slave   vid,
  output logic [COORD_W-1:0] hcount_l,
  output logic [COORD_W-1:0] hcount_r,
  output logic [COORD_W-1:0] vcount_l,
  output logic [COORD_W-1:0] vcount_r,
  output logic               o_win_valid,
  output logic               o_frame_done
);

  localparam int unsigned      MISS_W   = $clog2(HOLD_FRAMES + 1);
  localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(HOLD_FRAMES);

  lpr_state_t         state_q, state_d;
  logic               vsync_q, vsync_d;
  logic               valid_q, valid_d;
  lpr_win_t           win_q, win_d;
  logic               win_valid_q, win_valid_d;
  logic               frame_done_q, frame_done_d;
  logic [MISS_W-1:0]  miss_cnt_q, miss_cnt_d;

  logic               vsync_rise;
  logic               acc_clear;
  logic               acc_en;
  logic               box_ok;
  logic [MISS_W-1:0]  miss_inc;
  lpr_win_t           win_new;
  logic [COORD_W-1:0] xmin, xmax, ymin, ymax;
  logic [CNT_W-1:0]   pix_cnt;
  logic [COORD_W:0]   box_w, box_h;

  assign vsync_d    = vid.i_vsync;
  assign vsync_rise = vid.i_vsync & ~vsync_q;

  lpr_bbox_accum u_accum (
    .pixelclk  (pixelclk),
    .reset_n   (reset_n),
    .i_clear   (acc_clear),
    .i_en      (acc_en),
    .i_x       (vid.hcount),
    .i_y       (vid.vcount),
    .o_xmin    (xmin),
    .o_xmax    (xmax),
    .o_ymin    (ymin),
    .o_ymax    (ymax),
    .o_pix_cnt (pix_cnt)
  );

  // Next state and accumulator control
  always_comb begin
    state_d   = state_q;
    acc_clear = 1'b0;
    acc_en    = 1'b0;
    case (state_q)
      IDLE: begin
        acc_clear = 1'b1;
        if (i_enable) state_d = SYNC;
      end
      SYNC: begin
        acc_clear = 1'b1;
        if (vsync_rise) state_d = ACCUM;
      end
      ACCUM: begin
        acc_en = ~vsync_rise & vid.i_de & vid.i_mask;
        if (vsync_rise) state_d = CHECK;
      end
      CHECK:   state_d = COMMIT;
      COMMIT: begin
        acc_clear = 1'b1;
        state_d   = ACCUM;
      end
      default: state_d = IDLE;
    endcase
    if (!i_enable) state_d = IDLE;
  end

  // Pixel count is tested first; an empty box has xmax < xmin and is rejected regardless.
  always_comb begin
    box_w   = {1'b0, xmax} - {1'b0, xmin};
    box_h   = {1'b0, ymax} - {1'b0, ymin};
    box_ok  = (pix_cnt >= CNT_W'(MIN_PIX)) && (xmax >= xmin) && (ymax >= ymin) &&
              (box_w >= (COORD_W+1)'(MIN_W)) && (box_h >= (COORD_W+1)'(MIN_H));
    valid_d = (state_q == CHECK) ? box_ok : valid_q;
  end

  always_comb begin
    win_new.h_l  = bound_lo(xmin, MARGIN);
    win_new.h_r  = bound_hi(xmax, MARGIN, H_ACTIVE);
    win_new.v_l  = bound_lo(ymin, MARGIN);
    win_new.v_r  = bound_hi(ymax, MARGIN, V_ACTIVE);

    win_d        = win_q;
    win_valid_d  = win_valid_q;
    miss_cnt_d   = miss_cnt_q;
    frame_done_d = 1'b0;
    miss_inc     = (miss_cnt_q == MISS_MAX) ? MISS_MAX : miss_cnt_q + 1'b1;
    // A falling enable in COMMIT sends the FSM to IDLE and suppresses the update.
    if (state_q == COMMIT && i_enable) begin
      frame_done_d = 1'b1;
      if (valid_q) begin
        win_d       = win_new;
        win_valid_d = 1'b1;
        miss_cnt_d  = '0;
      end else begin
        miss_cnt_d = miss_inc;
        if (miss_inc == MISS_MAX) begin
          win_d       = NULL_WIN;
          win_valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      vsync_q      <= 1'b0;
      valid_q      <= 1'b0;
      win_q        <= NULL_WIN;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      vsync_q      <= vsync_d;
      valid_q      <= valid_d;
      win_q        <= win_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign hcount_l     = win_q.h_l;
  assign hcount_r     = win_q.h_r;
  assign vcount_l     = win_q.v_l;
  assign vcount_r     = win_q.v_r;
  assign o_win_valid  = win_valid_q;
  assign o_frame_done = frame_done_q;

endmodule
